// File: rtl/mac_array_pipe.sv
// Multi-lane pipelined signed dot-product engine: S1 registers products, S2 accumulates LEN terms.
// Define MAC_ARRAY_SATURATE_EN for saturating accumulation with a per-lane sat_flag; otherwise wraps.
module mac_array_pipe #(
    parameter int LANES  = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 19,
    parameter int LEN    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     acc_clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*DATA_W-1:0]  a_in,
    input  logic [LANES*DATA_W-1:0]  b_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*ACC_W-1:0]   result,
    output logic [LANES-1:0]         sat_flag
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    logic                     s1_valid;
    logic                     s1_last;
    logic [CNT_W-1:0]         term_cnt;
    logic signed [PROD_W-1:0] s1_prod  [LANES];
    logic signed [PROD_W-1:0] prod     [LANES];
    logic signed [ACC_W-1:0]  acc      [LANES];
    logic signed [ACC_W-1:0]  acc_base [LANES];
    logic signed [ACC_W-1:0]  sum      [LANES];
    logic                     acc_first;
    logic                     s2_advance;
    logic                     s2_fire;
    logic                     accept;

    // A last term may only leave S1 when the result register is free or draining.
    assign s2_advance = s1_valid && (!s1_last || !out_valid || out_ready);
    assign s2_fire    = s2_advance && !acc_clear;
    assign in_ready   = !acc_clear && (!s1_valid || s2_advance);
    assign accept     = in_valid && in_ready;

`ifdef MAC_ARRAY_SATURATE_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic signed [ACC_W:0] sum_wide [LANES];
    logic [LANES-1:0]      lane_sat;
    logic [LANES-1:0]      sticky;
    logic [LANES-1:0]      sticky_next;
    logic [LANES-1:0]      sat_q;
`endif

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod[i]     = PROD_W'($signed(a_in[i*DATA_W +: DATA_W])) *
                          PROD_W'($signed(b_in[i*DATA_W +: DATA_W]));
            acc_base[i] = acc_first ? '0 : acc[i];
`ifdef MAC_ARRAY_SATURATE_EN
            sum_wide[i] = (ACC_W+1)'(acc_base[i]) + (ACC_W+1)'(s1_prod[i]);
            lane_sat[i] = sum_wide[i][ACC_W] != sum_wide[i][ACC_W-1];
            if (!lane_sat[i])
                sum[i] = sum_wide[i][ACC_W-1:0];
            else if (sum_wide[i][ACC_W])
                sum[i] = ACC_MIN;
            else
                sum[i] = ACC_MAX;
`else
            sum[i] = acc_base[i] + ACC_W'(s1_prod[i]);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            term_cnt <= '0;
            for (int i = 0; i < LANES; i++) s1_prod[i] <= '0;
        end else if (acc_clear) begin
            s1_valid <= 1'b0;
            term_cnt <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_last  <= (term_cnt == LAST_CNT);
            term_cnt <= (term_cnt == LAST_CNT) ? '0 : term_cnt + CNT_W'(1);
            for (int i = 0; i < LANES; i++) s1_prod[i] <= prod[i];
        end else if (s2_advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_first <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            for (int i = 0; i < LANES; i++) acc[i] <= '0;
        end else begin
            if (acc_clear) begin
                acc_first <= 1'b1;
            end else if (s2_fire) begin
                if (s1_last) begin
                    for (int i = 0; i < LANES; i++) result[i*ACC_W +: ACC_W] <= sum[i];
                    acc_first <= 1'b1;
                end else begin
                    for (int i = 0; i < LANES; i++) acc[i] <= sum[i];
                    acc_first <= 1'b0;
                end
            end
            if (s2_fire && s1_last)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
        end
    end

`ifdef MAC_ARRAY_SATURATE_EN
    // Sticky restarts with the first term of each dot product.
    assign sticky_next = (acc_first ? '0 : sticky) | lane_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= '0;
            sat_q  <= '0;
        end else if (acc_clear) begin
            sticky <= '0;
        end else if (s2_fire) begin
            if (s1_last) begin
                sat_q  <= sticky_next;
                sticky <= '0;
            end else begin
                sticky <= sticky_next;
            end
        end
    end

    assign sat_flag = sat_q;
`else
    assign sat_flag = '0;
`endif

endmodule

// File: tb/tb_mac_array_pipe.sv
// Self-checking bench for mac_array_pipe (LEN=4, ACC_W=16) against an arithmetic reference model.
module tb_mac_array_pipe;

    localparam int LANES  = 4;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int LEN    = 4;
    localparam longint MAXV = (longint'(1) << (ACC_W-1)) - 1;
    localparam longint MINV = -(longint'(1) << (ACC_W-1));
    localparam longint MODV = longint'(1) << ACC_W;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    acc_clear;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] a_in;
    logic [LANES*DATA_W-1:0] b_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*ACC_W-1:0]  result;
    logic [LANES-1:0]        sat_flag;

    int checks = 0;
    int errors = 0;

    longint                 m_acc [LANES];
    int                     m_cnt;
    logic [LANES-1:0]       m_sticky;
    logic [LANES*ACC_W-1:0] q_res [$];
    logic [LANES-1:0]       q_sat [$];

    mac_array_pipe #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN(LEN)) dut (
        .clk(clk), .rst_n(rst_n), .acc_clear(acc_clear),
        .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic void model_clear();
        m_cnt    = 0;
        m_sticky = '0;
        for (int i = 0; i < LANES; i++) m_acc[i] = 0;
    endfunction

    // Dot product in plain integer arithmetic, reduced to ACC_W at each step.
    function automatic void model_accept(input logic [LANES*DATA_W-1:0] a, input logic [LANES*DATA_W-1:0] b);
        logic [LANES*ACC_W-1:0] r;
        longint av, bv, s;
        for (int i = 0; i < LANES; i++) begin
            av = longint'($signed(a[i*DATA_W +: DATA_W]));
            bv = longint'($signed(b[i*DATA_W +: DATA_W]));
            s  = m_acc[i] + av * bv;
`ifdef MAC_ARRAY_SATURATE_EN
            if (s > MAXV) begin s = MAXV; m_sticky[i] = 1'b1; end
            else if (s < MINV) begin s = MINV; m_sticky[i] = 1'b1; end
`else
            s = s % MODV;
            if (s < 0) s = s + MODV;
            if (s > MAXV) s = s - MODV;
`endif
            m_acc[i] = s;
        end
        m_cnt++;
        if (m_cnt == LEN) begin
            for (int i = 0; i < LANES; i++) r[i*ACC_W +: ACC_W] = ACC_W'(m_acc[i]);
            q_res.push_back(r);
            q_sat.push_back(m_sticky);
            model_clear();
        end
    endfunction

    function automatic logic [LANES*DATA_W-1:0] rep(input int v);
        logic [LANES*DATA_W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = DATA_W'(v);
        return r;
    endfunction

    function automatic logic [LANES*ACC_W-1:0] rep_res(input int v);
        logic [LANES*ACC_W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*ACC_W +: ACC_W] = ACC_W'(v);
        return r;
    endfunction

    // Offers one beat and waits (bounded) until it is accepted; the model sees it on acceptance.
    task automatic drive_beat(input logic [LANES*DATA_W-1:0] a, input logic [LANES*DATA_W-1:0] b);
        bit ok = 0;
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk);
        end
        if (ok) model_accept(a, b);
        #1 in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL beat_accept: in_ready never rose, got 0 expected 1");
        end
    endtask

    task automatic wait_ov();
        bit ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (out_valid) ok = 1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL out_valid_wait: got out_valid=0 expected 1 within 20 cycles");
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (result !== '0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
        checks++;
        if (sat_flag !== '0) begin errors++; $display("FAIL reset_sat_flag: got %b expected 0", sat_flag); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_basic();
        logic [LANES*ACC_W-1:0] exp_r;
        for (int k = 0; k < LEN; k++) drive_beat(rep(3), rep(4));
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency_early: got out_valid=%b expected 0", out_valid); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got out_valid=%b expected 1", out_valid); end
        exp_r = q_res.pop_front();
        void'(q_sat.pop_front());
        checks++;
        if (result !== rep_res(48)) begin errors++; $display("FAIL basic_result: got %h expected %h", result, rep_res(48)); end
        checks++;
        if (result !== exp_r) begin errors++; $display("FAIL basic_model: got %h expected %h", result, exp_r); end
        checks++;
        if (sat_flag !== '0) begin errors++; $display("FAIL basic_sat: got %b expected 0", sat_flag); end
        consume();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got out_valid=%b expected 0", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_mixed();
        int ma [LANES] = '{-1, 50, -128, 5};
        int mb [LANES] = '{-1, 60, 64, -6};
        int ex [LANES] = '{4, 12000, -32768, 0};
        logic [LANES*DATA_W-1:0] a, b;
        logic [LANES*ACC_W-1:0] exp_c, exp_r;
        for (int k = 0; k < LEN; k++) begin
            for (int i = 0; i < LANES; i++) begin
                a[i*DATA_W +: DATA_W] = DATA_W'(ma[i]);
                b[i*DATA_W +: DATA_W] = DATA_W'((i == 3 && k % 2 == 1) ? 6 : mb[i]);
            end
            drive_beat(a, b);
        end
        wait_ov();
        for (int i = 0; i < LANES; i++) exp_c[i*ACC_W +: ACC_W] = ACC_W'(ex[i]);
        exp_r = q_res.pop_front();
        void'(q_sat.pop_front());
        checks++;
        if (result !== exp_c) begin errors++; $display("FAIL mixed_result: got %h expected %h", result, exp_c); end
        checks++;
        if (result !== exp_r) begin errors++; $display("FAIL mixed_model: got %h expected %h", result, exp_r); end
        consume();
    endtask

    task automatic test_saturate();
        logic [LANES*DATA_W-1:0] a, b;
        logic [LANES*ACC_W-1:0] exp_c, exp_r;
        logic [LANES-1:0] exp_s, exp_ms;
        a = {8'sd1, -8'sd128, 8'sd127, 8'sd127};
        b = {8'sd1, 8'sd127, 8'sd127, 8'sd127};
`ifdef MAC_ARRAY_SATURATE_EN
        exp_c = {16'sd4, -16'sd32768, 16'sd32767, 16'sd32767};
        exp_s = 4'b0111;
`else
        exp_c = {16'sd4, 16'sd512, -16'sd1020, -16'sd1020};
        exp_s = 4'b0000;
`endif
        for (int k = 0; k < LEN; k++) drive_beat(a, b);
        wait_ov();
        exp_r  = q_res.pop_front();
        exp_ms = q_sat.pop_front();
        checks++;
        if (result !== exp_c) begin errors++; $display("FAIL sat_result: got %h expected %h", result, exp_c); end
        checks++;
        if (result !== exp_r) begin errors++; $display("FAIL sat_model: got %h expected %h", result, exp_r); end
        checks++;
        if (sat_flag !== exp_s) begin errors++; $display("FAIL sat_flag: got %b expected %b", sat_flag, exp_s); end
        checks++;
        if (sat_flag !== exp_ms) begin errors++; $display("FAIL sat_flag_model: got %b expected %b", sat_flag, exp_ms); end
        consume();
    endtask

    task automatic test_back_to_back();
        int got = 0;
        logic [LANES*ACC_W-1:0] exp_r;
        out_ready = 1'b0;
        for (int k = 0; k < 2*LEN; k++) drive_beat(rep(2), rep(2));
        in_valid = 1'b1;
        a_in = rep(9);
        b_in = rep(9);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
        checks++;
        if (out_valid !== 1'b1 || result !== rep_res(16)) begin
            errors++; $display("FAIL bp_held: got v=%b r=%h expected v=1 r=%h", out_valid, result, rep_res(16));
        end
        repeat (3) @(negedge clk);
        checks++;
        if (result !== rep_res(16) || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_stable: got r=%h rdy=%b expected r=%h rdy=0", result, in_ready, rep_res(16));
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) begin
                got++;
                exp_r = (q_res.size() > 0) ? q_res.pop_front() : '0;
                if (q_sat.size() > 0) void'(q_sat.pop_front());
                checks++;
                if (result !== exp_r || result !== rep_res(16)) begin
                    errors++; $display("FAIL bp_drain_value: got %h expected %h", result, exp_r);
                end
            end
            @(posedge clk);
        end
        #1 out_ready = 1'b0;
        checks++;
        if (got != 2) begin errors++; $display("FAIL bp_result_count: got %0d expected 2", got); end
    endtask

    task automatic test_abort();
        logic [LANES*ACC_W-1:0] exp_r;
        for (int k = 0; k < 3; k++) drive_beat(rep(7), rep(6));
        acc_clear = 1'b1;
        in_valid  = 1'b1;
        a_in = rep(7);
        b_in = rep(6);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready: got %b expected 0", in_ready); end
        @(posedge clk);
        #1 acc_clear = 1'b0;
        in_valid = 1'b0;
        model_clear();
        for (int k = 0; k < LEN; k++) drive_beat(rep(1), rep(3));
        wait_ov();
        exp_r = q_res.pop_front();
        void'(q_sat.pop_front());
        checks++;
        if (result !== rep_res(12)) begin errors++; $display("FAIL abort_result: got %h expected %h", result, rep_res(12)); end
        checks++;
        if (result !== exp_r) begin errors++; $display("FAIL abort_model: got %h expected %h", result, exp_r); end
        consume();
    endtask

    task automatic test_reset_mid();
        logic [LANES*ACC_W-1:0] exp_r;
        for (int k = 0; k < LEN; k++) drive_beat(rep(1), rep(1));
        wait_ov();
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) drive_beat(rep(2), rep(2));
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== '0 || sat_flag !== '0) begin
            errors++; $display("FAIL midreset_clear: got v=%b r=%h s=%b expected all 0", out_valid, result, sat_flag);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready); end
        q_res.delete();
        q_sat.delete();
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < LEN; k++) drive_beat(rep(2), rep(5));
        wait_ov();
        exp_r = q_res.pop_front();
        void'(q_sat.pop_front());
        checks++;
        if (result !== rep_res(40)) begin errors++; $display("FAIL midreset_result: got %h expected %h", result, rep_res(40)); end
        checks++;
        if (result !== exp_r) begin errors++; $display("FAIL midreset_model: got %h expected %h", result, exp_r); end
        consume();
    endtask

    task automatic test_random();
        logic [LANES*ACC_W-1:0] exp_r, held_r;
        logic [LANES-1:0] exp_s, held_s;
        bit holding = 0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a_in      = LANES*DATA_W'($urandom);
            b_in      = LANES*DATA_W'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (holding) begin
                checks++;
                if (out_valid !== 1'b1 || result !== held_r || sat_flag !== held_s) begin
                    errors++; $display("FAIL rand_hold: got v=%b r=%h s=%b expected v=1 r=%h s=%b",
                                       out_valid, result, sat_flag, held_r, held_s);
                end
            end
            holding = out_valid && !out_ready;
            held_r  = result;
            held_s  = sat_flag;
            if (out_valid && out_ready) begin
                exp_r = (q_res.size() > 0) ? q_res.pop_front() : 'x;
                exp_s = (q_sat.size() > 0) ? q_sat.pop_front() : 'x;
                checks++;
                if (result !== exp_r || sat_flag !== exp_s) begin
                    errors++; $display("FAIL rand_result: got r=%h s=%b expected r=%h s=%b", result, sat_flag, exp_r, exp_s);
                end
            end
            if (in_valid && in_ready) model_accept(a_in, b_in);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) begin
                exp_r = (q_res.size() > 0) ? q_res.pop_front() : 'x;
                exp_s = (q_sat.size() > 0) ? q_sat.pop_front() : 'x;
                checks++;
                if (result !== exp_r || sat_flag !== exp_s) begin
                    errors++; $display("FAIL rand_drain: got r=%h s=%b expected r=%h s=%b", result, sat_flag, exp_r, exp_s);
                end
            end
            @(posedge clk);
        end
        #1 out_ready = 1'b0;
        checks++;
        if (q_res.size() != 0) begin errors++; $display("FAIL rand_missing: got %0d results outstanding expected 0", q_res.size()); end
    endtask

    initial begin
        rst_n     = 1'b0;
        acc_clear = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_mixed();
        test_saturate();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
